// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer
//   Drives the PLL reset, qualifies the PLL lock flag and releases the
//   downstream system reset only after lock has been stable. Retries lock
//   acquisition on timeout and latches a fault after repeated timeouts.
//
// Ports:
//   clk          50 MHz reference clock (same net as the PLL refclk)
//   reset_n      asynchronous active-low reset
//   locked       PLL lock flag, asynchronous to clk
//   force_reseq  single-cycle request to restart the sequence
//   clear_fault  single-cycle fault acknowledge
//   pll_rst      active-high reset to the PLL
//   sys_reset_n  active-low reset for the downstream system
//   ready        high only in RUN
//   fault        high only in FAULT
//   retry_cnt    lock timeouts since the last RUN entry
//   lol_cnt      loss-of-lock events while in RUN, saturating
module pll_lock_sequencer #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 100000,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 4,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             locked,
  input  logic             force_reseq,
  input  logic             clear_fault,
  output logic             pll_rst,
  output logic             sys_reset_n,
  output logic             ready,
  output logic             fault,
  output logic [CNT_W-1:0] retry_cnt,
  output logic [CNT_W-1:0] lol_cnt
);

  typedef enum logic [2:0] {
    RST_PLL   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } state_t;

  localparam logic [31:0]      RST_LAST = 32'(RST_CYCLES - 1);
  localparam logic [31:0]      TO_LAST  = 32'(LOCK_TIMEOUT - 1);
  localparam logic [31:0]      ST_LAST  = 32'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] MAX_R    = CNT_W'(MAX_RETRIES);

  state_t           state, state_nx;
  logic [31:0]      cnt;
  logic             cnt_clr;
  logic [1:0]       sync_q;
  logic             locked_s;
  logic [CNT_W-1:0] retry_nx, lol_nx;

  // 2-flop synchronizer; only locked_s is used downstream.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= 2'b00;
    else          sync_q <= {sync_q[0], locked};
  end
  assign locked_s = sync_q[1];

  always_comb begin
    state_nx = state;
    cnt_clr  = 1'b0;
    retry_nx = retry_cnt;
    lol_nx   = lol_cnt;
    case (state)
      // Latched: locked and force_reseq are ignored, only clear_fault exits.
      FAULT: begin
        if (clear_fault) begin
          state_nx = RST_PLL;
          retry_nx = '0;
        end
      end
      default: begin
        if (force_reseq) begin
          // cnt_clr covers the RST_PLL -> RST_PLL restart, where no state change clears cnt.
          state_nx = RST_PLL;
          cnt_clr  = 1'b1;
        end else begin
          case (state)
            RST_PLL: if (cnt == RST_LAST) state_nx = WAIT_LOCK;
            WAIT_LOCK: begin
              if (locked_s) begin
                state_nx = STABLE;
              end else if (cnt == TO_LAST) begin
                retry_nx = retry_cnt + 1'b1;
                state_nx = (retry_nx == MAX_R) ? FAULT : RST_PLL;
              end
            end
            STABLE: begin
              if (!locked_s) begin
                state_nx = WAIT_LOCK;
              end else if (cnt == ST_LAST) begin
                state_nx = RUN;
                retry_nx = '0;
              end
            end
            RUN: begin
              if (!locked_s) begin
                state_nx = RST_PLL;
                if (lol_cnt != '1) lol_nx = lol_cnt + 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
    endcase
  end

  // Outputs decode the next state so they move on the same edge as the state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= RST_PLL;
      cnt         <= '0;
      retry_cnt   <= '0;
      lol_cnt     <= '0;
      pll_rst     <= 1'b1;
      sys_reset_n <= 1'b0;
      ready       <= 1'b0;
      fault       <= 1'b0;
    end else begin
      state     <= state_nx;
      retry_cnt <= retry_nx;
      lol_cnt   <= lol_nx;
      if (cnt_clr || (state_nx != state)) cnt <= '0;
      else if (cnt != '1)                 cnt <= cnt + 32'd1;
      pll_rst     <= (state_nx == RST_PLL) || (state_nx == FAULT);
      sys_reset_n <= (state_nx == RUN);
      ready       <= (state_nx == RUN);
      fault       <= (state_nx == FAULT);
    end
  end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer with small timing parameters.
module tb_pll_lock_sequencer;

  logic       clk = 1'b0;
  logic       reset_n, locked, force_reseq, clear_fault;
  logic       pll_rst, sys_reset_n, ready, fault;
  logic [7:0] retry_cnt, lol_cnt;

  int total = 0;
  int bad   = 0;

  pll_lock_sequencer #(
    .RST_CYCLES(4), .LOCK_TIMEOUT(20), .STABLE_CYCLES(8), .MAX_RETRIES(2), .CNT_W(8)
  ) dut (
    .clk(clk), .reset_n(reset_n), .locked(locked), .force_reseq(force_reseq),
    .clear_fault(clear_fault), .pll_rst(pll_rst), .sys_reset_n(sys_reset_n),
    .ready(ready), .fault(fault), .retry_cnt(retry_cnt), .lol_cnt(lol_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic lk; logic fr; logic cf; int n;
    logic e_prst; logic e_srn; logic e_rdy; logic e_flt; int e_retry; int e_lol;
  } vec_t;

  vec_t tbl[10];

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic wait_ready(input string nm, input int bound);
    int k;
    k = 0;
    while (!ready && k < bound) begin tick(1); k++; end
    chk(nm, int'(ready), 1);
  endtask

  task automatic do_reset(input logic lk);
    reset_n = 1'b0; locked = lk; force_reseq = 1'b0; clear_fault = 1'b0;
    tick(2);
    reset_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_lol;
    logic early;
    logic exp_p;

    // Clean lock, then force_reseq from RUN. Edge counts are from reset release.
    tbl[0] = '{1'b0, 1'b0, 1'b0, 3, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0}; // e3
    tbl[1] = '{1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0}; // e4 pll_rst drops
    tbl[2] = '{1'b0, 1'b0, 1'b0, 6, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0}; // e10
    tbl[3] = '{1'b1, 1'b0, 1'b0, 9, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0}; // e19, locked sampled at e11
    tbl[4] = '{1'b1, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0}; // e20
    tbl[5] = '{1'b1, 1'b0, 1'b0, 1, 1'b0, 1'b1, 1'b1, 1'b0, 0, 0}; // e21 RUN (11th edge)
    tbl[6] = '{1'b1, 1'b0, 1'b0, 5, 1'b0, 1'b1, 1'b1, 1'b0, 0, 0};
    tbl[7] = '{1'b1, 1'b1, 1'b0, 1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0}; // force_reseq
    tbl[8] = '{1'b1, 1'b0, 1'b0, 3, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0};
    tbl[9] = '{1'b1, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0};

    reset_n = 1'b0; locked = 1'b0; force_reseq = 1'b0; clear_fault = 1'b0;
    tick(3);
    chk("rst.pll_rst", int'(pll_rst), 1);
    chk("rst.sys_reset_n", int'(sys_reset_n), 0);
    chk("rst.ready", int'(ready), 0);
    chk("rst.fault", int'(fault), 0);
    chk("rst.retry_cnt", int'(retry_cnt), 0);
    chk("rst.lol_cnt", int'(lol_cnt), 0);

    // 1: clean lock (table)
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      locked = tbl[i].lk; force_reseq = tbl[i].fr; clear_fault = tbl[i].cf;
      tick(tbl[i].n);
      force_reseq = 1'b0; clear_fault = 1'b0;
      chk($sformatf("v%0d.pll_rst", i), int'(pll_rst), int'(tbl[i].e_prst));
      chk($sformatf("v%0d.sys_reset_n", i), int'(sys_reset_n), int'(tbl[i].e_srn));
      chk($sformatf("v%0d.ready", i), int'(ready), int'(tbl[i].e_rdy));
      chk($sformatf("v%0d.fault", i), int'(fault), int'(tbl[i].e_flt));
      chk($sformatf("v%0d.retry_cnt", i), int'(retry_cnt), tbl[i].e_retry);
      chk($sformatf("v%0d.lol_cnt", i), int'(lol_cnt), tbl[i].e_lol);
    end

    // 2: unstable lock, final rise sampled at e19 -> RUN at e29
    do_reset(1'b0);
    tick(10); locked = 1'b1;
    tick(5);  locked = 1'b0;
    tick(3);  locked = 1'b1;
    early = 1'b0;
    for (int k = 19; k <= 28; k++) begin
      tick(1);
      if (ready || sys_reset_n) early = 1'b1;
    end
    chk("s2.no_early_run", int'(early), 0);
    tick(1);
    chk("s2.ready", int'(ready), 1);
    chk("s2.sys_reset_n", int'(sys_reset_n), 1);
    chk("s2.retry_cnt", int'(retry_cnt), 0);

    // 3: timeout to fault
    do_reset(1'b0);
    for (int k = 1; k <= 48; k++) begin
      tick(1);
      exp_p = (k <= 3) || (k >= 24 && k <= 27) || (k == 48);
      chk($sformatf("s3.pll_rst@%0d", k), int'(pll_rst), int'(exp_p));
      chk($sformatf("s3.fault@%0d", k), int'(fault), (k == 48) ? 1 : 0);
      chk($sformatf("s3.retry@%0d", k), int'(retry_cnt), (k >= 48) ? 2 : ((k >= 24) ? 1 : 0));
    end
    locked = 1'b1;
    tick(5);
    chk("s3.fault_held", int'(fault), 1);
    chk("s3.pll_rst_held", int'(pll_rst), 1);
    chk("s3.srn_low", int'(sys_reset_n), 0);
    force_reseq = 1'b1; tick(1); force_reseq = 1'b0;
    chk("s5.force_in_fault", int'(fault), 1);
    chk("s5.force_in_fault_retry", int'(retry_cnt), 2);
    clear_fault = 1'b1; locked = 1'b0; tick(1); clear_fault = 1'b0;
    chk("s3.clear.fault", int'(fault), 0);
    chk("s3.clear.retry", int'(retry_cnt), 0);
    chk("s3.clear.pll_rst", int'(pll_rst), 1);
    tick(3);
    chk("s3.pulse_hi", int'(pll_rst), 1);
    tick(1);
    chk("s3.pulse_lo", int'(pll_rst), 0);

    // 4: loss of lock in RUN
    do_reset(1'b1);
    wait_ready("s4.first_run", 40);
    chk("s4.lol0", int'(lol_cnt), 0);
    locked = 1'b0; tick(1); locked = 1'b1;
    chk("s4.srn@1", int'(sys_reset_n), 1);
    tick(1);
    chk("s4.srn@2", int'(sys_reset_n), 1);
    tick(1);
    chk("s4.srn@3", int'(sys_reset_n), 0);
    chk("s4.ready@3", int'(ready), 0);
    chk("s4.lol1", int'(lol_cnt), 1);
    chk("s4.pll_rst@3", int'(pll_rst), 1);
    tick(3);
    chk("s4.pll_rst@6", int'(pll_rst), 1);
    tick(1);
    chk("s4.pll_rst@7", int'(pll_rst), 0);
    wait_ready("s4.relock", 40);
    chk("s4.lol_kept", int'(lol_cnt), 1);

    // 5: force_reseq wins over a simultaneous loss of lock
    locked = 1'b0; tick(1); locked = 1'b1; force_reseq = 1'b1;
    tick(1); force_reseq = 1'b0;
    chk("s5.prio.pll_rst", int'(pll_rst), 1);
    chk("s5.prio.srn", int'(sys_reset_n), 0);
    chk("s5.prio.lol", int'(lol_cnt), 1);
    tick(6);
    chk("s5.stable.pll_rst", int'(pll_rst), 0);
    chk("s5.stable.srn", int'(sys_reset_n), 0);
    reset_n = 1'b0;
    #1;
    chk("s5.async.pll_rst", int'(pll_rst), 1);
    chk("s5.async.lol", int'(lol_cnt), 0);
    chk("s5.async.srn", int'(sys_reset_n), 0);
    chk("s5.async.ready", int'(ready), 0);
    tick(2);

    // 6: lol_cnt saturation
    reset_n = 1'b1; locked = 1'b1;
    exp_lol = 0;
    for (int ev = 0; ev < 300; ev++) begin
      wait_ready($sformatf("s6.run%0d", ev), 40);
      locked = 1'b0; tick(1); locked = 1'b1;
      tick(2);
      exp_lol = (exp_lol == 255) ? 255 : exp_lol + 1;
      chk($sformatf("s6.lol%0d", ev), int'(lol_cnt), exp_lol);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pll_lock_sequencer.md
Name: pll_lock_sequencer

Overview:
- Companion block for the system PLL wrapper: it drives the PLL `rst` input and consumes the PLL `locked` output.
- Sequences PLL reset and lock acquisition, qualifies lock stability, and releases a system reset for the 100 MHz domains only after lock has been stable.
- Detects loss of lock, retries acquisition, and enters a latched fault state after repeated timeouts.
- Runs on the 50 MHz reference clock, the same clock that feeds the PLL `refclk`.

Parameters:
- RST_CYCLES, 16: cycles that `pll_rst` is held high per reset attempt (≥2).
- LOCK_TIMEOUT, 100000: cycles allowed in WAIT_LOCK before a retry (2 ms at 50 MHz).
- STABLE_CYCLES, 1024: consecutive synchronized-lock cycles required before release.
- MAX_RETRIES, 4: number of lock timeouts that causes FAULT (≥1).
- CNT_W, 8: width of the status counters.

Ports:
- clk  in  1  50 MHz reference clock; the same net as the PLL `refclk`.
- reset_n  in  1  asynchronous active-low reset.
- locked  in  1  PLL lock flag; asynchronous to `clk`.
- force_reseq  in  1  synchronous single-cycle request to restart the sequence.
- clear_fault  in  1  synchronous single-cycle fault acknowledge.
- pll_rst  out  1  active-high reset to the PLL.
- sys_reset_n  out  1  active-low reset for the downstream system.
- ready  out  1  high only in RUN.
- fault  out  1  high only in FAULT.
- retry_cnt  out  CNT_W  lock timeouts since the last RUN entry.
- lol_cnt  out  CNT_W  loss-of-lock events while in RUN; saturates at all-ones.

Behaviour:
- Synchronization: `locked` passes through a 2-flop synchronizer, output `locked_s`. Only `locked_s` is used.
- Single counter `cnt`, 32-bit or sized to max(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES). It is cleared on every state change.
- Reset (reset_n=0):
  - state=RST_PLL, cnt=0, synchronizer=0.
  - pll_rst=1, sys_reset_n=0, ready=0, fault=0, retry_cnt=0, lol_cnt=0.
- All outputs are registered and are decoded from the next state, so they change on the same edge as the state.
- RST_PLL: pll_rst=1.
  - On the edge where cnt==RST_CYCLES-1, go to WAIT_LOCK and drop pll_rst.
  - pll_rst is therefore high exactly RST_CYCLES cycles per attempt.
- WAIT_LOCK: pll_rst=0.
  - If locked_s=1, go to STABLE.
  - Else, on the edge where cnt==LOCK_TIMEOUT-1, increment retry_cnt. If the new value equals MAX_RETRIES, go to FAULT; otherwise go to RST_PLL.
  - If locked_s=1 on the timeout cycle, lock wins.
- STABLE:
  - If locked_s=0, return to WAIT_LOCK. This is not counted as a retry.
  - Else, on the edge where cnt==STABLE_CYCLES-1, go to RUN.
  - Net latency: sys_reset_n rises STABLE_CYCLES+3 edges after the first edge that samples `locked`=1 from WAIT_LOCK.
- RUN: sys_reset_n=1, ready=1, retry_cnt cleared on entry.
  - If locked_s=0, go to RST_PLL and increment lol_cnt (saturating).
  - sys_reset_n falls on that same edge, so there is no glitch-free window in which the system runs without lock beyond the synchronizer delay (2 cycles).
- FAULT: pll_rst=1 held, sys_reset_n=0, fault=1.
  - `locked` is ignored.
  - clear_fault=1 moves to RST_PLL, clears retry_cnt, and fault falls.
- force_reseq:
  - In any state except FAULT, it moves to RST_PLL with cnt=0. From RUN it also drops sys_reset_n.
  - It does not touch lol_cnt or retry_cnt.
  - Priority over all other transitions in the same cycle.
- clear_fault outside FAULT is ignored. In FAULT, force_reseq is ignored; only clear_fault exits.
- Counter saturation: retry_cnt cannot exceed MAX_RETRIES. lol_cnt holds at 2^CNT_W-1.
- Asserting reset_n mid-sequence immediately returns to the reset values, with no dependency on the clock.
- sys_reset_n assertion is asynchronous through reset_n. Its deassertion is always synchronous to clk.

Test Plan:
All scenarios use RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=2, CNT_W=8.
1. Clean lock: release reset_n; `locked` rises 10 cycles later and stays high -> pll_rst high for exactly the first 4 cycles; sys_reset_n and ready rise 11 edges after `locked` is first sampled; retry_cnt=0, lol_cnt=0.
2. Unstable lock: `locked` high for 5 cycles, low for 3, then high permanently -> no RUN during the glitch; RUN is reached 11 edges after the final rise; retry_cnt=0.
3. Timeout to fault: `locked` held low -> two pll_rst pulses of 4 cycles each, separated by 20 cycles; fault=1 exactly 48 cycles after reset release; retry_cnt=2; pll_rst stays high; then pulse clear_fault -> fault=0, retry_cnt=0, new 4-cycle pll_rst pulse.
4. Loss of lock in RUN: from RUN, drop `locked` for 1 cycle -> sys_reset_n falls 3 edges later, lol_cnt=1, pll_rst high 4 cycles; re-lock returns to RUN.
5. Priority and resets: force_reseq and `locked` drop in the same RUN cycle -> RST_PLL, lol_cnt unchanged; force_reseq in FAULT -> ignored; reset_n pulsed low mid-STABLE -> all outputs at reset values immediately without a clock edge.
6. Saturation: 300 loss-of-lock cycles in RUN -> lol_cnt holds at 255.
